// File: rtl/alu.sv
// Registered 32-bit, 8-operation ALU for the RCPU execute stage.
// F/ZF/OF update one clock after operands are captured with en=1.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_f;
  logic             w_lt;
  logic             w_of;
  logic [WIDTH-1:0] r_f;
  logic             r_zf;
  logic             r_of;

  assign w_sum  = A + B;
  assign w_diff = A - B;
  // Signed compare on the operands directly, so SLT stays correct when A-B overflows.
  assign w_lt   = $signed(A) < $signed(B);

  always_comb begin
    w_f  = '0;
    w_of = 1'b0;
    case (alu_op_e'(ALU_OP))
      OP_AND: w_f = A & B;
      OP_OR:  w_f = A | B;
      OP_XOR: w_f = A ^ B;
      OP_NOR: w_f = ~(A | B);
      OP_ADD: begin
        w_f  = w_sum;
        w_of = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        w_f  = w_diff;
        w_of = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
      end
      OP_SLT: w_f = WIDTH'(w_lt);
      OP_SLL: w_f = B << A[SHW-1:0];
      default: w_f = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f  <= '0;
      r_zf <= 1'b0;
      r_of <= 1'b0;
    end else if (en) begin
      r_f  <= w_f;
      r_zf <= (w_f == '0);
      r_of <= w_of;
    end
  end

  assign F  = r_f;
  assign ZF = r_zf;
  assign OF = r_of;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus hold/reset-priority sequences,
// expected results queued at drive time and compared when the registered output appears.
module tb_alu;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  ALU_OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] F;
  logic        ZF;
  logic        OF;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .ALU_OP(ALU_OP),
    .A(A), .B(B), .F(F), .ZF(ZF), .OF(OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
    logic        zf;
    logic        of;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] f;
    logic        zf;
    logic        of;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_f;
  logic        m_zf;
  logic        m_of;
  int          n_tests;
  int          n_fail;
  vec_t        vt[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] f, input logic zf, input logic of,
                              input string name);
    vec_t v;
    v.rst = r; v.en = e; v.op = op; v.a = a; v.b = b;
    v.f = f; v.zf = zf; v.of = of; v.name = name;
    return v;
  endfunction

  // Drive one vector, queue its expected outcome, then compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.rst; en = v.en; ALU_OP = v.op; A = v.a; B = v.b;
    if (v.rst) begin
      m_f = '0; m_zf = 1'b0; m_of = 1'b0;
    end else if (v.en) begin
      m_f = v.f; m_zf = v.zf; m_of = v.of;
    end
    e.f = m_f; e.zf = m_zf; e.of = m_of; e.name = v.name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = sb_q.pop_front();
      if (F !== got.f || ZF !== got.zf || OF !== got.of) begin
        n_fail++;
        $display("FAIL %s: got F=%08h ZF=%b OF=%b, expected F=%08h ZF=%b OF=%b",
                 got.name, F, ZF, OF, got.f, got.zf, got.of);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_f = '0; m_zf = 1'b0; m_of = 1'b0;
    rst = 1'b1; en = 1'b1; ALU_OP = 3'd0; A = '0; B = '0;

    vt.push_back(mk(1, 1, 3'd4, 32'hDEADBEEF, 32'hBEEFCAFE, 32'h0, 0, 0, "reset0"));
    vt.push_back(mk(1, 0, 3'd5, 32'h80000000, 32'h00000001, 32'h0, 0, 0, "reset1"));
    vt.push_back(mk(0, 1, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, "add_ff"));
    vt.push_back(mk(0, 1, 3'd5, 32'h0FFFFFFF, 32'hFFFFFFFF, 32'h10000000, 0, 0, "sub_neg"));
    vt.push_back(mk(0, 1, 3'd5, 32'h12345678, 32'h12345678, 32'h00000000, 1, 0, "sub_eq"));
    vt.push_back(mk(0, 1, 3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, "add_ovf"));
    vt.push_back(mk(0, 1, 3'd5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, "sub_ovf"));
    vt.push_back(mk(0, 1, 3'd4, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, "add_neg_ovf"));
    vt.push_back(mk(0, 1, 3'd5, 32'h00000000, 32'h80000000, 32'h80000000, 0, 1, "sub_min_ovf"));
    vt.push_back(mk(0, 1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, "and"));
    vt.push_back(mk(0, 1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, "or"));
    vt.push_back(mk(0, 1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, "xor"));
    vt.push_back(mk(0, 1, 3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, "nor"));
    vt.push_back(mk(0, 1, 3'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, "and_no_of"));
    vt.push_back(mk(0, 1, 3'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, "slt_neg"));
    vt.push_back(mk(0, 1, 3'd6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, "slt_pos"));
    vt.push_back(mk(0, 1, 3'd6, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, "slt_ovf"));
    vt.push_back(mk(0, 1, 3'd6, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, "slt_ovf2"));
    vt.push_back(mk(0, 1, 3'd6, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, "slt_eq"));
    vt.push_back(mk(0, 1, 3'd7, 32'h00000024, 32'h0000000F, 32'h000000F0, 0, 0, "sll4"));
    vt.push_back(mk(0, 1, 3'd7, 32'h0000001F, 32'h00000003, 32'h80000000, 0, 0, "sll31"));
    vt.push_back(mk(0, 1, 3'd7, 32'hFFFFFFE0, 32'h00000005, 32'h00000005, 0, 0, "sll_hi_ignored"));
    vt.push_back(mk(0, 1, 3'd7, 32'h00000010, 32'h00010001, 32'h00010000, 0, 0, "sll16"));

    for (int i = 0; i < vt.size(); i++) step(vt[i]);

    // Hold with nonzero flags, then with a plain result, while inputs churn.
    step(mk(0, 1, 3'd4, 32'h80000000, 32'h80000000, 32'h0, 1, 1, "load_flags"));
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 3'(i + 1), $urandom, $urandom, 32'h0, 0, 0, "hold_flags"));
    step(mk(0, 1, 3'd4, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, "load_3"));
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 3'(5 + i), 32'h7FFFFFFF, 32'h00000001, 32'h0, 0, 0, "hold_3"));

    // Reset wins over a concurrent capture.
    step(mk(0, 1, 3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, "load_ovf"));
    step(mk(1, 1, 3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h0, 0, 0, "rst_over_en"));
    step(mk(0, 0, 3'd4, 32'h00000005, 32'h00000005, 32'h0, 0, 0, "hold_after_rst"));
    step(mk(0, 1, 3'd4, 32'h00000005, 32'h00000005, 32'h0000000A, 0, 0, "resume"));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
